// File: rtl/regread_slice_sched_if.sv
// Issue-side bundle of the register-read slice scheduler: lane requests/grants,
// pipeline control, per-slice PRF read ports, stage-2 completion info and occupancy.
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif

interface regread_slice_sched_if #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_PORTS = 2,
  parameter int PHY_LOG   = `SIZE_PHYSICAL_LOG
);
  localparam int LANE_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W  = $clog2(2*NUM_PORTS+1);

  logic [NUM_REQ-1:0]           req_valid_i;
  logic [NUM_REQ*PHY_LOG-1:0]   req_tag_i;
  logic [NUM_REQ-1:0]           req_grant_o;
  logic                         stall_i;
  logic                         flush_i;
  logic [NUM_PORTS-1:0]         slice0_en_o;
  logic [NUM_PORTS-1:0]         slice1_en_o;
  logic [NUM_PORTS-1:0]         slice23_en_o;
  logic [NUM_PORTS*PHY_LOG-1:0] slice0_addr_o;
  logic [NUM_PORTS*PHY_LOG-1:0] slice1_addr_o;
  logic [NUM_PORTS*PHY_LOG-1:0] slice23_addr_o;
  logic [NUM_PORTS-1:0]         done_valid_o;
  logic [NUM_PORTS*LANE_W-1:0]  done_lane_o;
  logic [NUM_PORTS*PHY_LOG-1:0] done_tag_o;
  logic [CNT_W-1:0]             inflight_o;

  modport master (
    output req_valid_i, req_tag_i, stall_i, flush_i,
    input  req_grant_o, slice0_en_o, slice1_en_o, slice23_en_o,
           slice0_addr_o, slice1_addr_o, slice23_addr_o,
           done_valid_o, done_lane_o, done_tag_o, inflight_o
  );

  modport slave (
    input  req_valid_i, req_tag_i, stall_i, flush_i,
    output req_grant_o, slice0_en_o, slice1_en_o, slice23_en_o,
           slice0_addr_o, slice1_addr_o, slice23_addr_o,
           done_valid_o, done_lane_o, done_tag_o, inflight_o
  );
endinterface

// File: rtl/regread_slice_sched.sv
// Round-robin read-port arbiter feeding a 3-stage sliced PRF read pipeline
// (slice 0 at grant, slice 1 one cycle later, slices 2+3 plus completion after two).
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif

module regread_slice_sched #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_PORTS = 2,
  parameter int PHY_LOG   = `SIZE_PHYSICAL_LOG
) (
  input logic                    clk,
  input logic                    reset,
  regread_slice_sched_if.slave   bus
);

  localparam int LANE_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W  = $clog2(2*NUM_PORTS+1);

  typedef struct packed {
    logic              valid;
    logic [LANE_W-1:0] lane;
    logic [PHY_LOG-1:0] tag;
  } entry_t;

  logic [PHY_LOG-1:0] req_tag [NUM_REQ];
  logic [LANE_W-1:0]  rr_ptr;
  logic [LANE_W-1:0]  rr_ptr_nxt;
  logic [LANE_W-1:0]  scan_lane;
  logic [NUM_REQ-1:0] grant;
  int                 n_grant;
  logic               quiet;
  entry_t             s0 [NUM_PORTS];
  entry_t             s1 [NUM_PORTS];
  entry_t             s2 [NUM_PORTS];
  logic [CNT_W-1:0]   inflight;

  // Stall, flush and reset all suppress new grants and downstream enables.
  assign quiet = reset | bus.stall_i | bus.flush_i;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) req_tag[i] = bus.req_tag_i[i*PHY_LOG +: PHY_LOG];
  end

  always_comb begin
    // NOTE: every variable gets a default before the scan so no path leaves it unassigned (no latch).
    grant      = '0;
    rr_ptr_nxt = rr_ptr;
    scan_lane  = '0;
    n_grant    = 0;
    for (int k = 0; k < NUM_PORTS; k++) s0[k] = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_lane = LANE_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!quiet && bus.req_valid_i[scan_lane] && n_grant < NUM_PORTS) begin
        grant[scan_lane]      = 1'b1;
        s0[PORT_W'(n_grant)]  = '{valid: 1'b1, lane: scan_lane, tag: req_tag[scan_lane]};
        n_grant               = n_grant + 1;
        rr_ptr_nxt            = (int'(scan_lane) == NUM_REQ-1) ? '0 : scan_lane + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so S2 samples the old S1 on the same edge.
  always_ff @(posedge clk) begin
    if (reset) rr_ptr <= '0;
    else       rr_ptr <= rr_ptr_nxt;
  end

  // NOTE: lane/tag are cleared together with valid so idle ports always present zero addresses.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (reset || bus.flush_i) begin
        s1[k] <= '0;
        s2[k] <= '0;
      end else if (!bus.stall_i) begin
        s1[k] <= s0[k];
        s2[k] <= s1[k];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k < NUM_PORTS; k++)
      inflight = inflight + CNT_W'(s1[k].valid) + CNT_W'(s2[k].valid);
  end

  always_comb begin
    bus.req_grant_o    = grant;
    bus.inflight_o     = inflight;
    bus.slice0_en_o    = '0;
    bus.slice1_en_o    = '0;
    bus.slice23_en_o   = '0;
    bus.done_valid_o   = '0;
    bus.slice0_addr_o  = '0;
    bus.slice1_addr_o  = '0;
    bus.slice23_addr_o = '0;
    bus.done_tag_o     = '0;
    bus.done_lane_o    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      bus.slice0_en_o[k]                      = s0[k].valid;
      bus.slice0_addr_o[k*PHY_LOG +: PHY_LOG] = s0[k].tag;
      bus.slice1_en_o[k]                      = s1[k].valid & ~quiet;
      bus.slice1_addr_o[k*PHY_LOG +: PHY_LOG] = s1[k].tag;
      bus.slice23_en_o[k]                     = s2[k].valid & ~quiet;
      bus.done_valid_o[k]                     = s2[k].valid & ~quiet;
      bus.slice23_addr_o[k*PHY_LOG +: PHY_LOG] = s2[k].tag;
      bus.done_tag_o[k*PHY_LOG +: PHY_LOG]    = s2[k].tag;
      bus.done_lane_o[k*LANE_W +: LANE_W]     = s2[k].lane;
    end
  end

endmodule

// File: tb/tb_regread_slice_sched.sv
// Bench for regread_slice_sched: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-of-reads reference model.
module tb_regread_slice_sched;

  localparam int NR = 4;
  localparam int NP = 2;
  localparam int PL = 7;
  localparam int LW = 2;

  typedef struct {
    int lane;
    int tag;
    int port;
    int age;
  } item_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   rr     = 0;
  item_t q[$];

  regread_slice_sched_if #(.NUM_REQ(NR), .NUM_PORTS(NP), .PHY_LOG(PL)) bus ();

  regread_slice_sched #(.NUM_REQ(NR), .NUM_PORTS(NP), .PHY_LOG(PL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: each granted read is an item aging one step per unstalled cycle;
  // age 1 lives in slice 1, age 2 in slices 2+3, then it retires.
  task automatic model_cycle();
    logic [NR-1:0]    eg;
    logic [NP-1:0]    e0en, e1en, e23en;
    logic [NP*PL-1:0] e0a, e1a, e23a;
    logic [NP*LW-1:0] elane;
    logic [NR*PL-1:0] tags;
    logic             quiet;
    item_t            fresh[$];
    item_t            it;
    int               n, last, l;
    eg = '0; e0en = '0; e1en = '0; e23en = '0;
    e0a = '0; e1a = '0; e23a = '0; elane = '0;
    n = 0; last = 0;
    tags  = bus.req_tag_i;
    quiet = reset | bus.stall_i | bus.flush_i;
    if (!quiet) begin
      for (int i = 0; i < NR; i++) begin
        l = (rr + i) % NR;
        if (bus.req_valid_i[l] && n < NP) begin
          eg[l] = 1'b1;
          e0en[n] = 1'b1;
          e0a[n*PL +: PL] = tags[l*PL +: PL];
          it.lane = l; it.tag = int'(tags[l*PL +: PL]); it.port = n; it.age = 1;
          fresh.push_back(it);
          last = l;
          n++;
        end
      end
    end
    foreach (q[j]) begin
      if (q[j].age == 1) begin
        e1en[q[j].port] = !quiet;
        e1a[q[j].port*PL +: PL] = PL'(q[j].tag);
      end else begin
        e23en[q[j].port] = !quiet;
        e23a[q[j].port*PL +: PL] = PL'(q[j].tag);
        elane[q[j].port*LW +: LW] = LW'(q[j].lane);
      end
    end
    check("grant",        64'(bus.req_grant_o),    64'(eg));
    check("slice0_en",    64'(bus.slice0_en_o),    64'(e0en));
    check("slice0_addr",  64'(bus.slice0_addr_o),  64'(e0a));
    check("slice1_en",    64'(bus.slice1_en_o),    64'(e1en));
    check("slice1_addr",  64'(bus.slice1_addr_o),  64'(e1a));
    check("slice23_en",   64'(bus.slice23_en_o),   64'(e23en));
    check("slice23_addr", 64'(bus.slice23_addr_o), 64'(e23a));
    check("done_valid",   64'(bus.done_valid_o),   64'(e23en));
    check("done_tag",     64'(bus.done_tag_o),     64'(e23a));
    check("done_lane",    64'(bus.done_lane_o),    64'(elane));
    check("inflight",     64'(bus.inflight_o),     64'(q.size()));
    if (reset || bus.flush_i) begin
      q.delete();
      if (reset) rr = 0;
    end else if (!bus.stall_i) begin
      for (int j = q.size()-1; j >= 0; j--) begin
        q[j].age++;
        if (q[j].age > 2) q.delete(j);
      end
      foreach (fresh[j]) q.push_back(fresh[j]);
      if (n > 0) rr = (last + 1) % NR;
    end
  endtask

  task automatic cyc(input logic [NR-1:0] v, input logic [NR*PL-1:0] t,
                     input logic st, input logic fl, input logic rs);
    @(posedge clk);
    #1;
    bus.req_valid_i = v;
    bus.req_tag_i   = t;
    bus.stall_i     = st;
    bus.flush_i     = fl;
    reset           = rs;
    #4;
    model_cycle();
  endtask

  function automatic logic [NR*PL-1:0] tg(input int t3, input int t2, input int t1, input int t0);
    return {PL'(t3), PL'(t2), PL'(t1), PL'(t0)};
  endfunction

  initial begin
    logic [NR*PL-1:0] t;
    reset = 1'b1;
    bus.req_valid_i = '0;
    bus.req_tag_i   = '0;
    bus.stall_i     = 1'b0;
    bus.flush_i     = 1'b0;
    @(posedge clk);
    cyc('0, '0, 0, 0, 1);
    cyc('0, '0, 0, 0, 0);
    check("rst_inflight", 64'(bus.inflight_o), 64'd0);
    check("rst_done",     64'(bus.done_valid_o), 64'd0);

    // Single read, lane 2 tag 0x15 from rr_ptr 0
    t = tg(0, 'h15, 0, 0);
    cyc(4'b0100, t, 0, 0, 0);
    check("single_grant", 64'(bus.req_grant_o), 64'b0100);
    check("single_s0",    64'(bus.slice0_addr_o[PL-1:0]), 64'h15);
    cyc('0, t, 0, 0, 0);
    check("single_s1en",  64'(bus.slice1_en_o), 64'b01);
    check("single_s1",    64'(bus.slice1_addr_o[PL-1:0]), 64'h15);
    cyc('0, t, 0, 0, 0);
    check("single_done",  64'(bus.done_valid_o), 64'b01);
    check("single_tag",   64'(bus.done_tag_o[PL-1:0]), 64'h15);
    check("single_lane",  64'(bus.done_lane_o[LW-1:0]), 64'd2);

    // Wrap from rr_ptr 3: lane 3 -> port 0, lane 0 -> port 1
    t = tg('h33, 0, 0, 'h0a);
    cyc(4'b1001, t, 0, 0, 0);
    check("wrap_grant", 64'(bus.req_grant_o), 64'b1001);
    check("wrap_addr",  64'(bus.slice0_addr_o), 64'({PL'('h0a), PL'('h33)}));
    cyc(4'b0010, t, 0, 0, 0);
    check("wrap_ptr1",  64'(bus.req_grant_o), 64'b0010);
    cyc(4'b1000, t, 0, 0, 0);

    // Oversubscription from rr_ptr 0
    t = tg(4, 3, 2, 1);
    cyc(4'b1111, t, 0, 0, 0);
    check("over_c0", 64'(bus.req_grant_o), 64'b0011);
    cyc(4'b1111, t, 0, 0, 0);
    check("over_c1", 64'(bus.req_grant_o), 64'b1100);
    cyc(4'b0011, t, 0, 0, 0);
    check("over_ptr0", 64'(bus.req_grant_o), 64'b0011);
    cyc('0, t, 0, 0, 0);
    cyc('0, t, 0, 0, 0);
    cyc('0, t, 0, 0, 0);

    // Stall for two cycles after a single grant
    cyc(4'b0100, t, 0, 0, 0);
    cyc('0, t, 1, 0, 0);
    check("stall_s1en", 64'(bus.slice1_en_o), 64'd0);
    check("stall_infl", 64'(bus.inflight_o), 64'd1);
    cyc('0, t, 1, 0, 0);
    check("stall_done", 64'(bus.done_valid_o), 64'd0);
    check("stall_infl2", 64'(bus.inflight_o), 64'd1);
    cyc('0, t, 0, 0, 0);
    check("stall_rel_s1", 64'(bus.slice1_en_o), 64'b01);
    cyc('0, t, 0, 0, 0);
    check("stall_rel_done", 64'(bus.done_valid_o), 64'b01);

    // Flush with two generations in flight
    cyc(4'b0011, t, 0, 0, 0);
    cyc(4'b1100, t, 0, 0, 0);
    cyc('0, t, 0, 1, 0);
    check("flush_done", 64'(bus.done_valid_o), 64'd0);
    cyc('0, t, 0, 0, 0);
    check("flush_infl", 64'(bus.inflight_o), 64'd0);
    check("flush_done2", 64'(bus.done_valid_o), 64'd0);

    // Reset one cycle after a 2-port grant
    cyc(4'b1100, t, 0, 0, 0);
    cyc('0, t, 0, 0, 1);
    cyc('0, t, 0, 0, 0);
    check("rst_mid_infl", 64'(bus.inflight_o), 64'd0);
    check("rst_mid_done", 64'(bus.done_valid_o), 64'd0);
    cyc(4'b1111, t, 0, 0, 0);
    check("rst_mid_ptr", 64'(bus.req_grant_o), 64'b0011);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NR; i++) t[i*PL +: PL] = PL'($urandom);
      cyc(NR'($urandom), t,
          $urandom_range(7, 0) == 0,
          $urandom_range(15, 0) == 0,
          $urandom_range(63, 0) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/regread_slice_sched.md
REGREAD_SLICE_SCHED -- requirements
Module: regread_slice_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesting issue lanes.
REQ-002 SHALL have parameter NUM_PORTS, default 2, number of PRF read ports per slice (NUM_PORTS <= NUM_REQ).
REQ-003 SHALL have parameter PHY_LOG, default `SIZE_PHYSICAL_LOG, physical tag width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid_i  input  NUM_REQ  lane i requests a source-operand read.
REQ-007 SHALL have port req_tag_i  input  NUM_REQ*PHY_LOG  physical source tag per lane, lane i at bits [i*PHY_LOG +: PHY_LOG].
REQ-008 SHALL have port req_grant_o  output  NUM_REQ  combinational grant (ready) per lane.
REQ-009 SHALL have port stall_i  input  1  freeze the read pipeline.
REQ-010 SHALL have port flush_i  input  1  kill all in-flight reads.
REQ-011 SHALL have ports slice0_en_o/slice1_en_o/slice23_en_o  output  NUM_PORTS each  per-port read enables for slice 0, slice 1, slices 2+3.
REQ-012 SHALL have ports slice0_addr_o/slice1_addr_o/slice23_addr_o  output  NUM_PORTS*PHY_LOG each  per-port read addresses.
REQ-013 SHALL have ports done_valid_o  output  NUM_PORTS, done_lane_o  output  NUM_PORTS*$clog2(NUM_REQ), done_tag_o  output  NUM_PORTS*PHY_LOG  completion info at stage 2 (tag feeds the bypass compare stage).
REQ-014 SHALL have port inflight_o  output  $clog2(2*NUM_PORTS+1)  count of valid entries in stages 1 and 2.

Function
REQ-015 Arbitration SHALL scan lanes rr_ptr, rr_ptr+1, ... mod NUM_REQ and grant the first NUM_PORTS lanes with req_valid_i=1; the k-th granted lane is assigned port k.
REQ-016 req_grant_o SHALL be all-zero when stall_i=1, flush_i=1 or reset=1.
REQ-017 If at least one grant is issued, rr_ptr SHALL become (last granted lane + 1) mod NUM_REQ next cycle; otherwise rr_ptr SHALL hold.
REQ-018 Stage 0 (grant cycle, combinational): slice0_en_o[k]=1 and slice0_addr_o[k]=granted tag for each used port k; unused ports en=0, addr=0.
REQ-019 Stage 1 SHALL register {valid, lane, tag} per port from stage 0; slice1_en_o[k]=S1 valid, slice1_addr_o[k]=S1 tag, exactly 1 cycle after grant.
REQ-020 Stage 2 SHALL register stage 1; slice23_en_o[k], done_valid_o[k]=S2 valid, slice23_addr_o, done_tag_o, done_lane_o from S2, exactly 2 cycles after grant.
REQ-021 While stall_i=1 (flush_i=0): S1 and S2 SHALL hold contents; slice1_en_o, slice23_en_o and done_valid_o SHALL be forced 0; on release the held entries re-drive enables in the first unstalled cycle.
REQ-022 flush_i=1 SHALL clear all S1 and S2 valid bits next cycle; flush takes priority over stall; no done_valid_o during the flush cycle.
REQ-023 Advance when unstalled: S2<=S1, S1<=S0 in the same edge; entries never skip or duplicate.
REQ-024 inflight_o SHALL equal popcount(S1 valid)+popcount(S2 valid) as registered state.
REQ-025 Lanes with req_valid_i=0 SHALL never be granted; lanes without grant SHALL keep their request (no internal queuing).

Reset
REQ-026 On reset=1 at a posedge: rr_ptr=0, all S1/S2 valid=0, lane/tag fields=0; next cycle all enables, done_valid_o, inflight_o read 0.
REQ-027 Reset mid-operation SHALL discard in-flight entries with no done_valid_o pulse afterward.

Verification
REQ-028 Single read: lane 2 valid, tag 0x15, rr_ptr 0 -> grant 0b0100, port0 slice0 addr 0x15 cycle 0, slice1 cycle 1, slice23+done(lane 2, tag 0x15) cycle 2.
REQ-029 Oversubscription: all 4 lanes valid for 2 cycles, rr_ptr 0 -> cycle 0 grants lanes 0,1 (ports 0,1), cycle 1 grants lanes 2,3, rr_ptr returns to 0.
REQ-030 Stall: grant at cycle 0, stall_i=1 cycles 1-2 -> no enables/done in cycles 1-2; slice1 en cycle 3, done cycle 4; inflight_o=1 during stall.
REQ-031 Flush: grants in cycles 0 and 1, flush_i at cycle 2 -> no done_valid_o from cycle 2 on, inflight_o=0 at cycle 3.
REQ-032 Wrap: rr_ptr=3, lanes 3 and 0 valid -> lane 3 on port 0, lane 0 on port 1, rr_ptr becomes 1.
REQ-033 Reset at cycle 1 after a 2-port grant -> no done_valid_o, inflight_o=0 at cycle 2, rr_ptr=0.
